// File: rtl/sync_arbiter.sv
// Round-robin arbiter serialising N asynchronous four-phase requesters onto a
// single downstream four-phase channel. Inputs are synchronised internally;
// every output is registered on clk.
module sync_arbiter #(
    parameter int unsigned N           = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned W          = (N > 2) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] ack,
    output logic         r0,
    input  logic         a0,
    output logic [W-1:0] grant_idx,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StActive  = 2'd2,
        StRelease = 2'd3
    } state_t;

    state_t               state;
    logic   [W-1:0]       ptr;
    logic   [W-1:0]       g;

    logic   [N-1:0]       req_sync [SYNC_STAGES];
    logic   [SYNC_STAGES-1:0] a0_sync;
    logic   [N-1:0]       req_s;
    logic                 a0_s;

    logic                 win_valid;
    logic   [W-1:0]       win_idx;
    logic   [W-1:0]       ptr_next;

    // Synchroniser chains for every asynchronous handshake input.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                req_sync[i] <= '0;
            end
            a0_sync <= '0;
        end else begin
            req_sync[0] <= req;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                req_sync[i] <= req_sync[i-1];
            end
            a0_sync <= {a0_sync[SYNC_STAGES-2:0], a0};
        end
    end

    assign req_s = req_sync[SYNC_STAGES-1];
    assign a0_s  = a0_sync[SYNC_STAGES-1];

    // Round-robin pick: first set bit scanning from ptr upward with wrap mod N.
    // Scanning the offsets downward lets the smallest offset win last.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            int unsigned idx;
            idx = (int'(ptr) + k) % N;
            if (req_s[idx]) begin
                win_valid = 1'b1;
                win_idx   = W'(idx);
            end
        end
    end

    // Pointer advances past the owner being released, wrapping for any N.
    always_comb begin
        ptr_next = (g == W'(N - 1)) ? '0 : g + 1'b1;
    end

    // Handshake FSM with registered outputs; a protocol violation only flags err.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= StIdle;
            ptr   <= '0;
            g     <= '0;
            r0    <= 1'b0;
            ack   <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (a0_s) begin
                        err <= 1'b1;
                    end else if (win_valid) begin
                        g     <= win_idx;
                        r0    <= 1'b1;
                        busy  <= 1'b1;
                        state <= StReq;
                    end
                end
                StReq: begin
                    if (!req_s[g]) begin
                        err <= 1'b1;
                    end else if (a0_s) begin
                        ack   <= N'(1) << g;
                        state <= StActive;
                    end
                end
                StActive: begin
                    if (!a0_s) begin
                        err <= 1'b1;
                    end else if (!req_s[g]) begin
                        r0    <= 1'b0;
                        state <= StRelease;
                    end
                end
                StRelease: begin
                    if (!a0_s) begin
                        ack   <= '0;
                        busy  <= 1'b0;
                        ptr   <= ptr_next;
                        state <= StIdle;
                    end
                end
                default: begin
                    r0    <= 1'b0;
                    ack   <= '0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

    assign grant_idx = g;

endmodule
